// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first through one
// full-adder cell, one bit per clock, and returns a registered sum/carry-out with a done pulse.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] rreg;
    logic [WIDTH-1:0] rnext;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fbit;
    logic             fcarry;
    logic             load;
    logic             step;
    logic             finish;

    // The single shared full-adder cell.
    assign fbit   = areg[0] ^ breg[0] ^ carry;
    assign fcarry = (areg[0] & breg[0]) | (areg[0] & carry) | (breg[0] & carry);

    // Shift-then-insert form keeps the WIDTH=1 case free of empty slices.
    always_comb begin
        rnext            = rreg >> 1;
        rnext[WIDTH-1]   = fbit;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            areg  <= '0;
            breg  <= '0;
            rreg  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                areg  <= a;
                breg  <= b;
                carry <= cin;
                rreg  <= '0;
                cnt   <= '0;
            end else if (step) begin
                areg  <= areg >> 1;
                breg  <= breg >> 1;
                carry <= fcarry;
                rreg  <= rnext;
                cnt   <= cnt + CW'(1);
            end
            if (finish) begin
                sum  <= rnext;
                cout <= fcarry;
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl: an 8-bit instance for the
// protocol scenarios and a 3-bit instance swept over every operand combination.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start3;
    logic [2:0] a3;
    logic [2:0] b3;
    logic       cin3;
    logic       busy3;
    logic       done3;
    logic [2:0] sum3;
    logic       cout3;

    int total = 0;
    int bad   = 0;
    logic [7:0] last_sum = 8'h00;
    logic       last_cout = 1'b0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_add_ctrl #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one 8-bit job from IDLE and follows it cycle by cycle to its done cycle.
    task automatic job8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic [7:0] es, input logic ec);
        a = av; b = bv; cin = cv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy_e0"}, busy, 1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk({tag, ".busy_run"}, busy, 1);
            chk({tag, ".done_run"}, done, 0);
            chk({tag, ".sum_hold"}, sum, last_sum);
        end
        @(negedge clk);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".busy_end"}, busy, 0);
        chk({tag, ".sum"}, sum, es);
        chk({tag, ".cout"}, cout, ec);
        last_sum  = es;
        last_cout = ec;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount;
        logic [31:0] exp3;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.sum", sum, 8'h00);
        chk("reset.cout", cout, 0);
        chk("reset.busy3", busy3, 0);

        // 1: basic add and latency
        job8("t1", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        @(negedge clk);
        chk("t1.done_clear", done, 0);
        chk("t1.sum_held", sum, 8'h96);

        // 2: carry-out and full ripple
        job8("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        job8("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        @(negedge clk);

        // 3: start while busy is ignored, inputs changing during RUN are ignored
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcount = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 2) begin
                start = 1'b1; a = 8'hAA; b = 8'h55;
            end else if (k == 3) begin
                start = 1'b0; a = 8'h33; b = 8'hCC; cin = 1'b1;
            end
            @(negedge clk);
            if (done) dcount++;
        end
        chk("t3.sum", sum, 8'h02);
        chk("t3.cout", cout, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("t3.one_done", dcount, 1);
        chk("t3.idle", busy, 0);
        last_sum = 8'h02; last_cout = 1'b0;

        // 4: back-to-back start in the done cycle
        job8("t4a", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4.busy_rise", busy, 1);
        chk("t4.done_fall", done, 0);
        chk("t4.sum_hold", sum, 8'h30);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("t4.busy_run", busy, 1);
        end
        @(negedge clk);
        chk("t4b.done", done, 1);
        chk("t4b.sum", sum, 8'h00);
        chk("t4b.cout", cout, 1);
        @(negedge clk);

        // 5: reset mid-operation aborts without a done pulse
        a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5.busy", busy, 0);
        chk("t5.done", done, 0);
        chk("t5.sum", sum, 8'h00);
        chk("t5.cout", cout, 0);
        dcount = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("t5.no_done", dcount, 0);
        last_sum = 8'h00; last_cout = 1'b0;
        job8("t5b", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
        @(negedge clk);

        // 6: exhaustive 3-bit sweep, each job started in the previous job's done cycle
        for (int unsigned av = 0; av < 8; av++) begin
            for (int unsigned bv = 0; bv < 8; bv++) begin
                for (int unsigned cv = 0; cv < 2; cv++) begin
                    a3 = 3'(av); b3 = 3'(bv); cin3 = 1'(cv); start3 = 1'b1;
                    @(negedge clk);
                    start3 = 1'b0;
                    @(negedge clk);
                    @(negedge clk);
                    chk("t6.done_early", done3, 0);
                    @(negedge clk);
                    exp3 = av + bv + cv;
                    chk("t6.done", done3, 1);
                    chk("t6.result", {28'd0, cout3, sum3}, exp3);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
